config_frame_loader: RTL

- Configuration-frame controller upstream of the fabric tile columns and rows.
- Accepts a stream of 32-bit configuration words over a valid/ready handshake.
- Assembles one frame of per-row data onto the row FrameData buses, then pulses the selected column's FrameStrobe bit.
- The terminating and fabric tiles forward FrameData and FrameStrobe from there.

---
 rtl/cfg_frame_pkg.sv | 9 +
 rtl/config_frame_loader_strobe_decoder.sv | 26 ++
 rtl/config_frame_loader.sv | 113 +++++++++++
 3 files changed

// File: rtl/cfg_frame_pkg.sv
// cfg_frame_pkg: shared FSM state and header field layout for the configuration frame loader
package cfg_frame_pkg;
  typedef enum logic [1:0] {IDLE, LOAD, DISCARD, STROBE} state_e;
  localparam int HDR_MARKER_BIT = 31;
  localparam int HDR_COL_LSB = 16;
  localparam int HDR_COL_W = 8;
  localparam int HDR_FRAME_LSB = 0;
  localparam int HDR_FRAME_W = 5;
endpackage

// File: rtl/config_frame_loader_strobe_decoder.sv
// frame_strobe_decoder: registered one-hot FrameStrobe from (col, frame, enable)
module frame_strobe_decoder #(
  parameter int NumCols = 10,
  parameter int MaxFramesPerCol = 20,
  parameter int COL_W = 8,
  parameter int FRAME_W = 5
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic [COL_W-1:0]                    col_i,
  input  logic [FRAME_W-1:0]                  frame_i,
  input  logic                                en_i,
  output logic [NumCols*MaxFramesPerCol-1:0]  strobe_o
);
  localparam int N = NumCols * MaxFramesPerCol;
  logic [N-1:0] strobe_q, strobe_d;
  always_comb begin
    strobe_d = '0;
    for (int i = 0; i < N; i++)
      strobe_d[i] = en_i && (col_i == COL_W'(i / MaxFramesPerCol)) && (frame_i == FRAME_W'(i % MaxFramesPerCol));
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) strobe_q <= '0;
    else strobe_q <= strobe_d;
  assign strobe_o = strobe_q;
endmodule

// File: rtl/config_frame_loader.sv
// config_frame_loader: assembles one frame of row data from a word stream, then strobes the addressed column frame
module config_frame_loader
  import cfg_frame_pkg::*;
#(
  parameter int FrameBitsPerRow = 32,
  parameter int MaxFramesPerCol = 20,
  parameter int NumRows = 16,
  parameter int NumCols = 10,
  parameter int StrobeCycles = 2
) (
  input  logic                                CLK,
  input  logic                                resetn,
  input  logic [FrameBitsPerRow-1:0]          in_data,
  input  logic                                in_valid,
  output logic                                in_ready,
  output logic [NumRows*FrameBitsPerRow-1:0]  FrameData,
  output logic [NumCols*MaxFramesPerCol-1:0]  FrameStrobe,
  output logic                                busy,
  output logic                                err,
  output logic [15:0]                         frames_written
);
  localparam int RW = NumRows > 1 ? $clog2(NumRows) : 1;
  localparam int SW = StrobeCycles > 1 ? $clog2(StrobeCycles) : 1;
  state_e state_q, state_d;
  logic [RW-1:0] row_q, row_d;
  logic [SW-1:0] cnt_q, cnt_d;
  logic [HDR_COL_W-1:0] col_q, col_d, hdr_col;
  logic [HDR_FRAME_W-1:0] frame_q, frame_d, hdr_frame;
  logic err_q, err_d;
  logic [15:0] fw_q, fw_d;
  logic [NumRows*FrameBitsPerRow-1:0] data_q;
  logic acc, marker, hdr_ok, last_row, last_strobe;
  assign acc = in_valid && in_ready;
  assign marker = in_data[HDR_MARKER_BIT];
  assign hdr_col = in_data[HDR_COL_LSB +: HDR_COL_W];
  assign hdr_frame = in_data[HDR_FRAME_LSB +: HDR_FRAME_W];
  assign hdr_ok = marker && hdr_col < HDR_COL_W'(NumCols) && hdr_frame < HDR_FRAME_W'(MaxFramesPerCol);
  assign last_row = row_q == RW'(NumRows - 1);
  assign last_strobe = cnt_q == SW'(StrobeCycles - 1);
  always_comb begin
    state_d = state_q;
    row_d = row_q;
    cnt_d = cnt_q;
    col_d = col_q;
    frame_d = frame_q;
    err_d = err_q;
    fw_d = fw_q;
    case (state_q)
      IDLE: if (acc) begin
        err_d = !hdr_ok;
        row_d = '0;
        if (hdr_ok) begin
          col_d = hdr_col;
          frame_d = hdr_frame;
          state_d = LOAD;
        end else if (marker) state_d = DISCARD;
      end
      LOAD: if (acc) begin
        row_d = row_q + 1'b1;
        cnt_d = '0;
        state_d = last_row ? STROBE : LOAD;
      end
      DISCARD: if (acc) begin
        row_d = row_q + 1'b1;
        state_d = last_row ? IDLE : DISCARD;
      end
      default: begin
        cnt_d = cnt_q + 1'b1;
        state_d = last_strobe ? IDLE : STROBE;
        fw_d = last_strobe ? fw_q + 16'd1 : fw_q;
      end
    endcase
  end
  always_ff @(posedge CLK or negedge resetn)
    if (!resetn) begin
      state_q <= IDLE;
      row_q <= '0;
      cnt_q <= '0;
      col_q <= '0;
      frame_q <= '0;
      err_q <= 1'b0;
      fw_q <= '0;
      data_q <= '0;
    end else begin
      state_q <= state_d;
      row_q <= row_d;
      cnt_q <= cnt_d;
      col_q <= col_d;
      frame_q <= frame_d;
      err_q <= err_d;
      fw_q <= fw_d;
      if (acc && state_q == LOAD) data_q[row_q*FrameBitsPerRow +: FrameBitsPerRow] <= in_data;
    end
  // the decoder registers on the same edge the FSM enters STROBE, so the pulse tracks the state exactly
  frame_strobe_decoder #(
    .NumCols(NumCols),
    .MaxFramesPerCol(MaxFramesPerCol),
    .COL_W(HDR_COL_W),
    .FRAME_W(HDR_FRAME_W)
  ) u_dec (
    .clk(CLK),
    .rst_n(resetn),
    .col_i(col_q),
    .frame_i(frame_q),
    .en_i(state_d == STROBE),
    .strobe_o(FrameStrobe)
  );
  assign in_ready = state_q != STROBE;
  assign busy = state_q != IDLE;
  assign err = err_q;
  assign frames_written = fw_q;
  assign FrameData = data_q;
endmodule
